// File: rtl/barrel_shifter_right_pipe_if.sv
// Handshake bundle for the pipelined right barrel shifter.
// master: producer/consumer side (execute stage); slave: the shifter itself.
interface barrel_shifter_right_pipe_if #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned SHW   = 6
);
    // Operand side
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_shift;
    logic             in_arith;
    logic             in_rot;

    // Result side
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output in_shift,
        output in_arith,
        output in_rot,
        input  in_ready,
        input  out_valid,
        input  out_data,
        output out_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_shift,
        input  in_arith,
        input  in_rot,
        output in_ready,
        output out_valid,
        output out_data,
        input  out_ready
    );
endinterface

// File: rtl/barrel_shifter_right_pipe.sv
// Pipelined right barrel shifter (SRL / SRA, optional ROR).
// An input capture register is followed by SHW shift stages; stage k resolves
// shift bit k, so a result appears SHW cycles after the accepting edge.
// Optional feature: define ROTATE_EN to enable rotate-right on in_rot = 1.
// Any stall freezes the whole pipe (no bubble compression).
module barrel_shifter_right_pipe #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned SHW   = 6
) (
    input logic                         clk,
    input logic                         rst,
    barrel_shifter_right_pipe_if.slave  shf_io
);

    if (SHW != $clog2(WIDTH)) begin : g_bad_param
        $error("SHW must equal log2(WIDTH)");
    end

    // Right shift by amt with a fill bit, or rotate when rot is set.
    function automatic logic [WIDTH-1:0] shr_stage(
        input logic [WIDTH-1:0] d,
        input logic             fill,
        input logic             rot,
        input int unsigned      amt
    );
        logic [WIDTH-1:0] shr;
        logic [WIDTH-1:0] fill_mask;
        shr       = d >> amt;
        fill_mask = ~({WIDTH{1'b1}} >> amt);
        if (rot) begin
            shr_stage = shr | (d << (WIDTH - amt));
        end else begin
            shr_stage = shr | (fill ? fill_mask : '0);
        end
    endfunction

    logic stall;

    // Index 0 is the capture register, index SHW is the output register.
    logic [SHW:0]     valid_q, valid_d;
    logic [WIDTH-1:0] data_q  [SHW+1];
    logic [WIDTH-1:0] data_d  [SHW+1];

    // Sideband travels with each operand through stages 0..SHW-1.
    logic [SHW-1:0]   shift_q [SHW];
    logic [SHW-1:0]   shift_d [SHW];
    logic [SHW-1:0]   arith_q, arith_d;
    logic [SHW-1:0]   fill_q,  fill_d;
`ifdef ROTATE_EN
    logic [SHW-1:0]   rot_q,   rot_d;
`endif

    assign stall            = shf_io.out_valid & ~shf_io.out_ready;
    assign shf_io.in_ready  = ~stall;
    assign shf_io.out_valid = valid_q[SHW];
    assign shf_io.out_data  = data_q[SHW];

    // Capture: fill bit is frozen here from the original sign bit.
    always_comb begin
        valid_d[0] = shf_io.in_valid & shf_io.in_ready;
        data_d[0]  = shf_io.in_data;
        shift_d[0] = shf_io.in_shift;
        arith_d[0] = shf_io.in_arith;
        fill_d[0]  = shf_io.in_arith & shf_io.in_data[WIDTH-1];
`ifdef ROTATE_EN
        rot_d[0]   = shf_io.in_rot;
`endif
    end

    // Sideband moves one stage per cycle alongside the data.
    always_comb begin
        for (int k = 1; k < int'(SHW); k++) begin
            shift_d[k] = shift_q[k-1];
            arith_d[k] = arith_q[k-1];
            fill_d[k]  = fill_q[k-1];
`ifdef ROTATE_EN
            rot_d[k]   = rot_q[k-1];
`endif
        end
    end

    // Stage k applies a 2^k shift when its registered shift bit is set.
    always_comb begin
        for (int k = 0; k < int'(SHW); k++) begin
            valid_d[k+1] = valid_q[k];
            if (shift_q[k][k]) begin
`ifdef ROTATE_EN
                data_d[k+1] = shr_stage(data_q[k], arith_q[k] & fill_q[k], rot_q[k],
                                        32'd1 << k);
`else
                data_d[k+1] = shr_stage(data_q[k], arith_q[k] & fill_q[k], 1'b0,
                                        32'd1 << k);
`endif
            end else begin
                data_d[k+1] = data_q[k];
            end
        end
    end

    // Already-resolved shift bits and the ignored rotate input feed nothing.
    logic unused_sideband;
    always_comb begin
        unused_sideband = 1'b0;
        for (int k = 0; k < int'(SHW); k++) begin
            unused_sideband = unused_sideband ^ (^shift_q[k]);
        end
`ifndef ROTATE_EN
        unused_sideband = unused_sideband ^ shf_io.in_rot;
`endif
    end

    // Pipe register: synchronous flush on reset, full hold while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            arith_q <= '0;
            fill_q  <= '0;
`ifdef ROTATE_EN
            rot_q   <= '0;
`endif
            for (int k = 0; k <= int'(SHW); k++) begin
                data_q[k] <= '0;
            end
            for (int k = 0; k < int'(SHW); k++) begin
                shift_q[k] <= '0;
            end
        end else if (!stall) begin
            valid_q <= valid_d;
            arith_q <= arith_d;
            fill_q  <= fill_d;
`ifdef ROTATE_EN
            rot_q   <= rot_d;
`endif
            for (int k = 0; k <= int'(SHW); k++) begin
                data_q[k] <= data_d[k];
            end
            for (int k = 0; k < int'(SHW); k++) begin
                shift_q[k] <= shift_d[k];
            end
        end
    end

endmodule
